// File: rtl/fft_ram_pkg.sv
// fft_ram_pkg
// Shared definitions for the paged multi-bank FFT sample memory:
//   - fsmState_t : page-control FSM states
//   - RD_LAT     : read latency in clocks (RAM register + output register)
//   - sliceLsb() : low bit of one bank's field in a flattened per-bank bus
package fft_ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    SWAP,
    CLEAR
  } fsmState_t;

  localparam int RD_LAT = 2;

  // Bank 'bank' occupies [sliceLsb(bank, width) +: width] of a flattened bus.
  function automatic int sliceLsb(input int bank, input int width);
    return bank * width;
  endfunction

endpackage

// File: rtl/fft_ram_dp.sv
// fft_ram_dp
// Simple dual-port RAM with one write port and one registered read port.
// Ports:
//   clk    : clock, rising edge
//   we     : write enable; wrData is stored at wrAddr
//   wrAddr : write address
//   wrData : write data
//   re     : read enable; rdData loads mem[rdAddr] on the next edge
//   rdAddr : read address
//   rdData : registered read data, holds while re is low
module fft_ram_dp #(
  parameter int D_BIT = 17,
  parameter int A_BIT = 11
) (
  input  logic             clk,
  input  logic             we,
  input  logic [A_BIT-1:0] wrAddr,
  input  logic [D_BIT-1:0] wrData,
  input  logic             re,
  input  logic [A_BIT-1:0] rdAddr,
  output logic [D_BIT-1:0] rdData
);

  // NOTE: the storage array has no reset so it maps onto block RAM; only
  // control state is reset, and the contents are simply undefined until written.
  logic [D_BIT-1:0] mem [2**A_BIT];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wrAddr] <= wrData;
    end
    if (re) begin
      rdData <= mem[rdAddr];
    end
  end

endmodule

// File: rtl/fft_ram_bank_pp.sv
// fft_ram_bank_pp
// N_BANK-bank complex sample memory with ping-pong pages. Reads come from page
// oPAGE, writes go to page ~oPAGE, so a butterfly stage reads one page while
// writing its results to the other.
// Ports:
//   iCLK, iRESET_N        : clock and synchronous active-low reset
//   iDATA_RE/iDATA_IM     : per-bank write data (flattened, D_BIT each)
//   iADDR_WR, iWE         : per-bank write address (within write page) / enable
//   iADDR_RD, iRD_EN      : per-bank read address (within read page) / enable
//   iSWAP                 : pulse, swap pages once in-flight reads have drained
//   iCLEAR                : pulse, zero-fill the write page
//   oDATA_RE/oDATA_IM     : per-bank read data, held between valid reads
//   oVALID                : per-bank read data valid (2-cycle latency)
//   oREADY                : accesses accepted (FSM idle)
//   oPAGE                 : current read page
//   oERR                  : sticky flag, access or request made while not ready
module fft_ram_bank_pp
  import fft_ram_pkg::*;
#(
  parameter int D_BIT  = 17,
  parameter int A_BIT  = 10,
  parameter int N_BANK = 4
) (
  input  logic                    iCLK,
  input  logic                    iRESET_N,
  input  logic [N_BANK*D_BIT-1:0] iDATA_RE,
  input  logic [N_BANK*D_BIT-1:0] iDATA_IM,
  input  logic [N_BANK*A_BIT-1:0] iADDR_WR,
  input  logic [N_BANK-1:0]       iWE,
  input  logic [N_BANK*A_BIT-1:0] iADDR_RD,
  input  logic [N_BANK-1:0]       iRD_EN,
  input  logic                    iSWAP,
  input  logic                    iCLEAR,
  output logic [N_BANK*D_BIT-1:0] oDATA_RE,
  output logic [N_BANK*D_BIT-1:0] oDATA_IM,
  output logic [N_BANK-1:0]       oVALID,
  output logic                    oREADY,
  output logic                    oPAGE,
  output logic                    oERR
);

  fsmState_t         state, stateNext;
  logic              clearing;
  logic              clrPend;
  logic [A_BIT-1:0]  clrCnt;
  logic              lastClr;
  logic [N_BANK-1:0] wrAcc, rdAcc;
  logic              rdInFlight;
  logic [N_BANK-1:0] vldPipe [RD_LAT];
  logic [D_BIT-1:0]  ramRe  [N_BANK];
  logic [D_BIT-1:0]  ramIm  [N_BANK];
  logic [D_BIT-1:0]  dataRe [N_BANK];
  logic [D_BIT-1:0]  dataIm [N_BANK];

  // Accesses outside IDLE are dropped.
  assign wrAcc   = iWE    & {N_BANK{oREADY}};
  assign rdAcc   = iRD_EN & {N_BANK{oREADY}};
  assign lastClr = (clrCnt == '1);

  // A read still needs the current page while it is being accepted or sits in
  // the RAM stage; once in the output stage it no longer depends on oPAGE.
  assign rdInFlight = (|rdAcc) || (|vldPipe[0]);

  // ---- FSM: state register ----
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge iCLK) begin
    if (!iRESET_N) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // ---- FSM: next-state logic ----
  // NOTE: stateNext gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (iSWAP) begin
          stateNext = rdInFlight ? DRAIN : SWAP;
        end else if (iCLEAR) begin
          stateNext = CLEAR;
        end
      end
      DRAIN:   if (~|vldPipe[0]) stateNext = SWAP;
      SWAP:    stateNext = clrPend ? CLEAR : IDLE;
      CLEAR:   if (lastClr) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // ---- FSM: output decode ----
  always_comb begin
    oREADY   = (state == IDLE);
    clearing = (state == CLEAR);
  end

  // Page, pending clear, clear counter and sticky error.
  always_ff @(posedge iCLK) begin
    if (!iRESET_N) begin
      oPAGE   <= 1'b0;
      clrPend <= 1'b0;
      clrCnt  <= '0;
      oERR    <= 1'b0;
    end else begin
      if (state == SWAP) begin
        oPAGE <= ~oPAGE;
      end
      // A clear requested together with a swap waits for the new write page.
      if (oREADY && iSWAP && iCLEAR) begin
        clrPend <= 1'b1;
      end else if (state == SWAP) begin
        clrPend <= 1'b0;
      end
      // Wraps back to 0 on the last address, ready for the next clear.
      if (clearing) begin
        clrCnt <= clrCnt + 1'b1;
      end
      if (!oREADY && (iSWAP || iCLEAR || (|iWE) || (|iRD_EN))) begin
        oERR <= 1'b1;
      end
    end
  end

  // Read-valid pipeline and output registers: stage 0 marks data in the RAM
  // register, the last stage is oVALID.
  always_ff @(posedge iCLK) begin
    if (!iRESET_N) begin
      for (int s = 0; s < RD_LAT; s++) begin
        vldPipe[s] <= '0;
      end
      for (int k = 0; k < N_BANK; k++) begin
        dataRe[k] <= '0;
        dataIm[k] <= '0;
      end
    end else begin
      vldPipe[0] <= rdAcc;
      for (int s = 1; s < RD_LAT; s++) begin
        vldPipe[s] <= vldPipe[s-1];
      end
      for (int k = 0; k < N_BANK; k++) begin
        if (vldPipe[0][k]) begin
          dataRe[k] <= ramRe[k];
          dataIm[k] <= ramIm[k];
        end
      end
    end
  end

  assign oVALID = vldPipe[RD_LAT-1];

  genvar k;
  for (k = 0; k < N_BANK; k++) begin : gBank
    localparam int DLSB = sliceLsb(k, D_BIT);
    localparam int ALSB = sliceLsb(k, A_BIT);

    logic             we;
    logic [A_BIT:0]   wrAddr;
    logic [A_BIT:0]   rdAddr;
    logic [D_BIT-1:0] wrRe, wrIm;

    // The clear sweep owns the write port of every bank while it runs.
    assign we     = clearing | wrAcc[k];
    assign wrAddr = {~oPAGE, (clearing ? clrCnt : iADDR_WR[ALSB +: A_BIT])};
    assign wrRe   = clearing ? '0 : iDATA_RE[DLSB +: D_BIT];
    assign wrIm   = clearing ? '0 : iDATA_IM[DLSB +: D_BIT];
    assign rdAddr = {oPAGE, iADDR_RD[ALSB +: A_BIT]};

    fft_ram_dp #(.D_BIT(D_BIT), .A_BIT(A_BIT + 1)) uRamRe (
      .clk    (iCLK),
      .we     (we),
      .wrAddr (wrAddr),
      .wrData (wrRe),
      .re     (rdAcc[k]),
      .rdAddr (rdAddr),
      .rdData (ramRe[k])
    );

    fft_ram_dp #(.D_BIT(D_BIT), .A_BIT(A_BIT + 1)) uRamIm (
      .clk    (iCLK),
      .we     (we),
      .wrAddr (wrAddr),
      .wrData (wrIm),
      .re     (rdAcc[k]),
      .rdAddr (rdAddr),
      .rdData (ramIm[k])
    );

    assign oDATA_RE[DLSB +: D_BIT] = dataRe[k];
    assign oDATA_IM[DLSB +: D_BIT] = dataIm[k];
  end

endmodule

// File: tb/tb_fft_ram_bank_pp.sv
// tb_fft_ram_bank_pp
// Self-checking bench for fft_ram_bank_pp (A_BIT=4, N_BANK=4, D_BIT=17).
// Read stimulus pushes the expected data and due cycle into a per-bank queue;
// a negedge monitor compares oVALID and data against the queue heads.
module tb_fft_ram_bank_pp;

  localparam int D_BIT  = 17;
  localparam int A_BIT  = 4;
  localparam int N_BANK = 4;

  typedef struct {
    int               due;
    logic [D_BIT-1:0] re;
    logic [D_BIT-1:0] im;
  } expT;

  logic                    iCLK = 1'b0;
  logic                    iRESET_N;
  logic [N_BANK*D_BIT-1:0] iDATA_RE, iDATA_IM;
  logic [N_BANK*A_BIT-1:0] iADDR_WR, iADDR_RD;
  logic [N_BANK-1:0]       iWE, iRD_EN;
  logic                    iSWAP, iCLEAR;
  logic [N_BANK*D_BIT-1:0] oDATA_RE, oDATA_IM;
  logic [N_BANK-1:0]       oVALID;
  logic                    oREADY, oPAGE, oERR;

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  bit  monOn  = 1'b0;
  expT expQ [N_BANK][$];
  expT monE;
  logic monV;
  int  low;

  fft_ram_bank_pp #(.D_BIT(D_BIT), .A_BIT(A_BIT), .N_BANK(N_BANK)) dut (
    .iCLK     (iCLK),
    .iRESET_N (iRESET_N),
    .iDATA_RE (iDATA_RE),
    .iDATA_IM (iDATA_IM),
    .iADDR_WR (iADDR_WR),
    .iWE      (iWE),
    .iADDR_RD (iADDR_RD),
    .iRD_EN   (iRD_EN),
    .iSWAP    (iSWAP),
    .iCLEAR   (iCLEAR),
    .oDATA_RE (oDATA_RE),
    .oDATA_IM (oDATA_IM),
    .oVALID   (oVALID),
    .oREADY   (oREADY),
    .oPAGE    (oPAGE),
    .oERR     (oERR)
  );

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: a bank must be valid exactly when its queue head is due.
  always @(negedge iCLK) begin
    if (monOn) begin
      for (int k = 0; k < N_BANK; k++) begin
        monV = (expQ[k].size() > 0) && (expQ[k][0].due == cyc);
        check($sformatf("valid_bank%0d", k), 32'(oVALID[k]), 32'(monV));
        if (monV) begin
          monE = expQ[k].pop_front();
          if (oVALID[k] === 1'b1) begin
            check($sformatf("re_bank%0d", k), 32'(oDATA_RE[k*D_BIT +: D_BIT]), 32'(monE.re));
            check($sformatf("im_bank%0d", k), 32'(oDATA_IM[k*D_BIT +: D_BIT]), 32'(monE.im));
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic idleIn();
    iWE    = '0;
    iRD_EN = '0;
    iSWAP  = 1'b0;
    iCLEAR = 1'b0;
  endtask

  task automatic setWrite(input int k, input int addr, input int re, input int im);
    iWE[k] = 1'b1;
    iADDR_WR[k*A_BIT +: A_BIT] = A_BIT'(addr);
    iDATA_RE[k*D_BIT +: D_BIT] = D_BIT'(re);
    iDATA_IM[k*D_BIT +: D_BIT] = D_BIT'(im);
  endtask

  task automatic setRead(input int k, input int addr, input int re, input int im);
    expT e;
    iRD_EN[k] = 1'b1;
    iADDR_RD[k*A_BIT +: A_BIT] = A_BIT'(addr);
    e.due = cyc + 2;
    e.re  = D_BIT'(re);
    e.im  = D_BIT'(im);
    expQ[k].push_back(e);
  endtask

  task automatic writeAll(input int addr, input int re, input int im, input int step);
    for (int k = 0; k < N_BANK; k++) setWrite(k, addr, re + step*k, im + step*k);
    tick(1);
    idleIn();
  endtask

  task automatic readAll(input int addr, input int re, input int im, input int step);
    for (int k = 0; k < N_BANK; k++) setRead(k, addr, re + step*k, im + step*k);
    tick(1);
    idleIn();
  endtask

  task automatic waitReady(output int lowCycles);
    lowCycles = 0;
    while (oREADY !== 1'b1 && lowCycles < 64) begin
      lowCycles++;
      tick(1);
    end
  endtask

  task automatic pulse(input bit sw, input bit cl, output int lowCycles);
    iSWAP  = sw;
    iCLEAR = cl;
    tick(1);
    idleIn();
    waitReady(lowCycles);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iRESET_N = 1'b0;
    iDATA_RE = '0;
    iDATA_IM = '0;
    iADDR_WR = '0;
    iADDR_RD = '0;
    idleIn();
    tick(3);

    // Reset state
    check("rst_ready", 32'(oREADY), 1);
    check("rst_page",  32'(oPAGE),  0);
    check("rst_err",   32'(oERR),   0);
    check("rst_valid", 32'(oVALID), 0);
    check("rst_re",    32'(oDATA_RE[31:0]), 0);
    check("rst_im",    32'(oDATA_IM[31:0]), 0);
    iRESET_N = 1'b1;
    monOn    = 1'b1;
    tick(1);

    // Write/read through a swap, bank 2 only
    setWrite(2, 5, 'h1234, 'h1FFFF);
    tick(1);
    idleIn();
    pulse(1'b1, 1'b0, low);
    check("swap1_low", 32'(low), 1);
    check("swap1_page", 32'(oPAGE), 1);
    setRead(2, 5, 'h1234, 'h1FFFF);
    tick(1);
    idleIn();
    tick(4);
    check("hold_re", 32'(oDATA_RE[2*D_BIT +: D_BIT]), 'h1234);
    check("hold_im", 32'(oDATA_IM[2*D_BIT +: D_BIT]), 'h1FFFF);

    // Ping-pong isolation on bank 0 addr 3
    setWrite(0, 3, 'hAAA, 'h555);          // page 0
    tick(1);
    idleIn();
    pulse(1'b1, 1'b0, low);
    check("iso_page0", 32'(oPAGE), 0);
    setWrite(0, 3, 7, 7);                  // page 1
    tick(1);
    idleIn();
    setRead(0, 3, 'hAAA, 'h555);           // still reads page 0
    tick(1);
    idleIn();
    tick(4);
    pulse(1'b1, 1'b0, low);
    check("iso_page1", 32'(oPAGE), 1);
    setRead(0, 3, 7, 7);
    tick(1);
    idleIn();
    tick(4);

    // Drain: reads at two consecutive cycles, swap with the second
    writeAll(1, 'h100, 'h200, 1);          // page 0
    writeAll(2, 'h300, 'h400, 1);
    pulse(1'b1, 1'b0, low);                // read page 0
    check("pre_drain_page", 32'(oPAGE), 0);
    writeAll(1, 'h500, 'h600, 1);          // page 1
    for (int k = 0; k < N_BANK; k++) setRead(k, 1, 'h100 + k, 'h200 + k);
    tick(1);
    idleIn();
    for (int k = 0; k < N_BANK; k++) setRead(k, 2, 'h300 + k, 'h400 + k);
    iSWAP = 1'b1;
    tick(1);
    idleIn();
    waitReady(low);
    check("drain_low", 32'(low), 3);
    check("drain_page", 32'(oPAGE), 1);
    readAll(1, 'h500, 'h600, 1);
    tick(4);

    // Clear: fill write page (0), clear it, swap, read all 64 locations
    for (int a = 0; a < 16; a++) writeAll(a, 'h155, 'h155, 0);
    pulse(1'b0, 1'b1, low);
    check("clear_low", 32'(low), 16);
    check("clear_page", 32'(oPAGE), 1);
    pulse(1'b1, 1'b0, low);
    check("clear_swap_page", 32'(oPAGE), 0);
    for (int a = 0; a < 16; a++) readAll(a, 0, 0, 0);
    tick(4);

    // Swap + clear together
    pulse(1'b1, 1'b0, low);                // page 1, write page 0
    writeAll(7, 'hABC, 'hDEF, 1);          // page 0
    pulse(1'b1, 1'b0, low);                // page 0, write page 1
    writeAll(7, 'h777, 'h888, 1);          // page 1
    readAll(7, 'hABC, 'hDEF, 1);
    tick(4);
    iSWAP  = 1'b1;
    iCLEAR = 1'b1;
    tick(1);
    idleIn();
    check("sc_swap_ready", 32'(oREADY), 0);
    check("sc_swap_page", 32'(oPAGE), 0);
    tick(1);
    check("sc_clear_page", 32'(oPAGE), 1);
    check("sc_clear_ready", 32'(oREADY), 0);
    waitReady(low);
    check("sc_clear_low", 32'(low), 16);
    readAll(7, 'h777, 'h888, 1);           // old write page kept
    tick(4);
    pulse(1'b1, 1'b0, low);
    check("sc_back_page", 32'(oPAGE), 0);
    readAll(7, 0, 0, 0);                   // old read page zeroed
    tick(4);

    // Errors: access and swap during CLEAR
    check("err_before", 32'(oERR), 0);
    pulse(1'b0, 1'b1, low);
    tick(0);
    iCLEAR = 1'b1;
    tick(1);
    idleIn();                              // CLEAR, cnt 0
    tick(4);                               // cnt 4
    setWrite(1, 0, 'h1ABCD, 'h1ABCD);
    iRD_EN[1] = 1'b1;
    iADDR_RD[1*A_BIT +: A_BIT] = '0;
    iSWAP = 1'b1;
    tick(1);
    idleIn();
    check("err_set", 32'(oERR), 1);
    waitReady(low);
    check("err_clear_low", 32'(low), 11);
    check("err_page_kept", 32'(oPAGE), 0);
    tick(3);
    check("err_held", 32'(oERR), 1);
    pulse(1'b1, 1'b0, low);
    check("err_swap_page", 32'(oPAGE), 1);
    setRead(1, 0, 0, 0);
    tick(1);
    idleIn();
    tick(4);

    // Reset in the middle of a CLEAR
    iCLEAR = 1'b1;
    tick(1);
    idleIn();
    tick(3);
    iRESET_N = 1'b0;
    tick(1);
    check("mid_rst_page",  32'(oPAGE),  0);
    check("mid_rst_ready", 32'(oREADY), 1);
    check("mid_rst_err",   32'(oERR),   0);
    check("mid_rst_valid", 32'(oVALID), 0);
    check("mid_rst_re",    32'(oDATA_RE[31:0]), 0);
    iRESET_N = 1'b1;
    tick(2);
    pulse(1'b1, 1'b0, low);
    check("post_rst_swap_low", 32'(low), 1);
    check("post_rst_page", 32'(oPAGE), 1);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_ram_bank_pp.md
# fft_ram_bank_pp

Parametrised multi-bank complex sample memory for the radix-4 FFT datapath, with ping-pong paging. It holds N_BANK independent banks. Each bank has one read port and one write port, and each port carries a real and an imaginary word. Every bank is split into two pages: butterflies read stage n from the read page while writing stage n+1 results to the other page. It adds four things: per-bank read-valid tracking, a drained page-swap handshake, a hardware clear of the write page, and access-error flagging.

## Interface
- D_BIT, 17, word width of each real/imag sample
- A_BIT, 10, address width within one page (page depth 2^A_BIT)
- N_BANK, 4, number of banks (≥1); bank k uses slice [k*D_BIT +: D_BIT] / [k*A_BIT +: A_BIT] / bit k
- iCLK  in  1  clock, all logic on rising edge
- iRESET_N  in  1  synchronous, active-low reset
- iDATA_RE, iDATA_IM  in  N_BANK*D_BIT  write data per bank
- iADDR_WR  in  N_BANK*A_BIT  write address per bank (within write page)
- iWE  in  N_BANK  write enable per bank
- iADDR_RD  in  N_BANK*A_BIT  read address per bank (within read page)
- iRD_EN  in  N_BANK  read enable per bank
- iSWAP  in  1  request page swap (single-cycle pulse)
- iCLEAR  in  1  request zero-fill of write page (single-cycle pulse)
- oDATA_RE, oDATA_IM  out  N_BANK*D_BIT  read data per bank
- oVALID  out  N_BANK  read data valid per bank
- oREADY  out  1  high when accesses are accepted (state IDLE)
- oPAGE  out  1  current read page; write page = ~oPAGE
- oERR  out  1  sticky access-while-not-ready flag

## Operation
- Physical bank address = {page, addr}. Each bank has RE and IM RAMs of depth 2^(A_BIT+1).
- Writes go to page ~oPAGE. Reads come from page oPAGE. Read and write pages are always distinct, so there is no read/write collision.
- States: IDLE, DRAIN, SWAP, CLEAR.
- IDLE: iWE/iRD_EN are honoured. In IDLE, iSWAP=1 goes to DRAIN if any read is in flight, else to SWAP. iCLEAR=1 (without iSWAP) goes to CLEAR with the counter at 0.
- DRAIN: waits until the read-valid pipeline is empty, then goes to SWAP.
- SWAP: one cycle; oPAGE toggles on exit. Goes to CLEAR if a clear is pending, else to IDLE.
- CLEAR: writes 0 to RE and IM of all banks at {~oPAGE, cnt}, with cnt running 0..2^A_BIT−1. After the last address it goes to IDLE.
- iSWAP and iCLEAR in the same IDLE cycle: the swap runs first. The clear is latched as pending and zero-fills the new write page.
- iSWAP or iCLEAR while not in IDLE: ignored, and oERR is set.
- Any iWE or iRD_EN bit high while oREADY=0: that access is dropped (no RAM write, no oVALID) and oERR is set.
- oERR stays set until reset.
- oDATA holds its last valid value when oVALID=0.
- Reset values:
  - state IDLE, oPAGE=0, oREADY=1, oERR=0, oVALID=0, oDATA_RE/IM=0.
  - Clear-pending flag and counter are 0.
  - RAM contents are not reset.
- Reset mid-CLEAR or mid-DRAIN aborts the operation. Memory is left partially cleared, and the page returns to 0.

## Timing
- Read latency is fixed at 2: address/enable at edge t, RAM registered at t+1, output register at t+2, with oVALID[k] high in the cycle after edge t+2.
- Writes take effect at the edge where iWE is sampled.
- oREADY is a decode of the registered state, so it drops in the cycle after iSWAP/iCLEAR is sampled.
- Swap with an empty pipeline: iSWAP at edge t; SWAP during cycle t+1; new oPAGE and oREADY=1 from edge t+2.
- Swap with reads in flight: at most 2 DRAIN cycles precede SWAP. In-flight reads complete from the old page.
- Clear: oREADY low for exactly 2^A_BIT cycles.
- Swap+clear: oREADY low for 1+2^A_BIT cycles, plus any DRAIN cycles.

## Structure
- Package fft_ram_pkg holds:
  - state enum (IDLE, DRAIN, SWAP, CLEAR);
  - localparam RD_LAT=2;
  - slice helper functions for flattened per-bank buses.
- Sub-module fft_ram_dp: simple dual-port RAM, 1 write port and 1 read port, registered read, parameters D_BIT and A_BIT+1. It is instantiated 2×N_BANK times in a generate loop.
- Top level holds the FSM, clear counter, valid pipeline, output registers and error flag.

## Test plan
All scenarios use A_BIT=4, N_BANK=4, D_BIT=17.
- Write/read: write bank 2 addr 5 = (RE 0x1234, IM 0x1FFFF), swap, read bank 2 addr 5 → oVALID[2] in the cycle after edge t+2 with that data; other oVALID bits stay 0.
- Ping-pong isolation: write 7 to bank 0 addr 3 on page 1, then read bank 0 addr 3 before the swap → returns the page-0 content, not 7. After the swap, reading returns 7 and oPAGE=1.
- Drain: issue reads on all banks at edges t and t+1, pulse iSWAP at t+1 → both reads return old-page data, oREADY is low 3 cycles (2 DRAIN + 1 SWAP), and oPAGE toggles afterwards.
- Clear: fill the write page with 0x155 everywhere, pulse iCLEAR → oREADY low 16 cycles; after the swap, all 64 locations read 0 in RE and IM.
- Simultaneous iSWAP+iCLEAR → oPAGE toggles after 1 cycle, then the new write page is zeroed over 16 cycles; the old write page (now the read page) keeps its data.
- Error and reset:
  - iWE[1] during CLEAR → no write, oERR=1 and held.
  - iRESET_N low mid-CLEAR → next cycle oPAGE=0, oREADY=1, oERR=0, oVALID=0.
